// File: rtl/vga_arb_pkg.sv
// +--------------------------------------------------------------------------+
// | vga_arb_pkg : shared lane width, fill FSM states and lane merge helper   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

package vga_arb_pkg;

  localparam int LANE_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_t;

  // Pick the freshly written byte for a lane that was hit, the stored byte otherwise.
  function automatic logic [LANE_W-1:0] lane_merge(
    input logic [LANE_W-1:0] i_old,
    input logic [LANE_W-1:0] i_new,
    input logic              i_sel
  );
    return i_sel ? i_new : i_old;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_arb_lane_ram.sv
// +--------------------------------------------------------------------------+
// | vga_arb_lane_ram : one byte lane, one write port, two registered reads   |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module vga_arb_lane_ram
  import vga_arb_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [DEPTH-1:0]  i_wa,
  input  logic [LANE_W-1:0] i_wd,
  input  logic              i_re_a,
  input  logic [DEPTH-1:0]  i_ra_a,
  output logic [LANE_W-1:0] o_q_a,
  input  logic              i_re_b,
  input  logic [DEPTH-1:0]  i_ra_b,
  output logic [LANE_W-1:0] o_q_b
);

  logic [LANE_W-1:0] r_mem [2**DEPTH];
  logic [LANE_W-1:0] r_q_a;
  logic [LANE_W-1:0] r_q_b;

  // Reads sample the array before this edge's write lands; outputs hold between reads.
  always_ff @(posedge clk) begin
    if (i_we)   r_mem[i_wa] <= i_wd;
    if (i_re_a) r_q_a <= r_mem[i_ra_a];
    if (i_re_b) r_q_b <= r_mem[i_ra_b];
  end

  assign o_q_a = r_q_a;
  assign o_q_b = r_q_b;

endmodule

`default_nettype wire

// File: rtl/vga_arb_linebuf.sv
// +--------------------------------------------------------------------------+
// | vga_arb_linebuf : byte-lane line buffer with FML burst fill, CPU port    |
// |                   and display read port. Optional write-to-read          |
// |                   forwarding with macro VGA_ARB_LINEBUF_FWD_EN.          |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module vga_arb_linebuf
  import vga_arb_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int LANES = 2,
  parameter int BURST = 8
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [DEPTH-1:0]        a,
  input  logic                    req,
  input  logic [LANES-1:0]        we,
  input  logic [LANE_W*LANES-1:0] di,
  output logic                    ack,
  output logic [LANE_W*LANES-1:0] dout,
  output logic                    dout_valid,
  input  logic [DEPTH-1:0]        a2,
  input  logic                    re2,
  output logic [LANE_W*LANES-1:0] do2,
  output logic                    do2_valid,
  input  logic                    fill_start,
  input  logic [DEPTH-1:0]        fill_base,
  input  logic                    fill_valid,
  input  logic [LANE_W*LANES-1:0] fill_di,
  output logic                    fill_busy,
  output logic                    fill_done
);

  localparam int W     = LANE_W * LANES;
  localparam int CNT_W = $clog2(BURST + 1);

  if (BURST > (1 << DEPTH)) begin : g_burst_chk
    $error("vga_arb_linebuf: BURST exceeds buffer depth");
  end

  fill_state_t      r_state;
  logic [DEPTH-1:0] r_faddr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_dv;
  logic             r_dv2;

  logic             w_fill_wr;
  logic [LANES-1:0] w_wr_lanes;
  logic [DEPTH-1:0] w_wa;
  logic [W-1:0]     w_wd;
  logic             w_re1;
  logic             w_re2;
  logic [W-1:0]     w_q1;
  logic [W-1:0]     w_q2;

  // Fill owns the array whenever it presents a word; the CPU port is stalled that cycle.
  assign w_fill_wr  = r_busy & fill_valid;
  assign ack        = req & ~w_fill_wr;
  assign w_wr_lanes = sys_rst_n ? ({LANES{w_fill_wr}} | ({LANES{ack}} & we)) : '0;
  assign w_wa       = w_fill_wr ? r_faddr : a;
  assign w_wd       = w_fill_wr ? fill_di : di;
  assign w_re1      = ack & sys_rst_n;
  assign w_re2      = re2 & sys_rst_n;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_faddr <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (fill_start) begin
            r_state <= ST_FILL;
            r_busy  <= 1'b1;
            r_faddr <= fill_base;
            r_cnt   <= '0;
          end
        end
        ST_FILL: begin
          if (fill_valid) begin
            r_faddr <= r_faddr + 1'b1;
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(BURST - 1)) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_dv  <= 1'b0;
      r_dv2 <= 1'b0;
    end else begin
      r_dv  <= ack;
      r_dv2 <= re2;
    end
  end

`ifdef VGA_ARB_LINEBUF_FWD_EN
  logic [LANES-1:0] r_hit1;
  logic [LANES-1:0] r_hit2;
  logic [W-1:0]     r_fwd1;
  logic [W-1:0]     r_fwd2;

  // Capture which lanes of the read address were written on the same edge.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_hit1 <= '0;
      r_hit2 <= '0;
      r_fwd1 <= '0;
      r_fwd2 <= '0;
    end else begin
      if (w_re1) begin
        r_hit1 <= w_wr_lanes & {LANES{w_wa == a}};
        r_fwd1 <= w_wd;
      end
      if (w_re2) begin
        r_hit2 <= w_wr_lanes & {LANES{w_wa == a2}};
        r_fwd2 <= w_wd;
      end
    end
  end
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vga_arb_lane_ram #(.DEPTH(DEPTH)) u_ram (
      .clk    (sys_clk),
      .i_we   (w_wr_lanes[i]),
      .i_wa   (w_wa),
      .i_wd   (w_wd[i*LANE_W +: LANE_W]),
      .i_re_a (w_re1),
      .i_ra_a (a),
      .o_q_a  (w_q1[i*LANE_W +: LANE_W]),
      .i_re_b (w_re2),
      .i_ra_b (a2),
      .o_q_b  (w_q2[i*LANE_W +: LANE_W])
    );
`ifdef VGA_ARB_LINEBUF_FWD_EN
    assign dout[i*LANE_W +: LANE_W] = lane_merge(w_q1[i*LANE_W +: LANE_W],
                                                 r_fwd1[i*LANE_W +: LANE_W], r_hit1[i]);
    assign do2[i*LANE_W +: LANE_W]  = lane_merge(w_q2[i*LANE_W +: LANE_W],
                                                 r_fwd2[i*LANE_W +: LANE_W], r_hit2[i]);
`else
    assign dout[i*LANE_W +: LANE_W] = w_q1[i*LANE_W +: LANE_W];
    assign do2[i*LANE_W +: LANE_W]  = w_q2[i*LANE_W +: LANE_W];
`endif
  end

  assign dout_valid = r_dv;
  assign do2_valid  = r_dv2;
  assign fill_busy  = r_busy;
  assign fill_done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_vga_arb_linebuf.sv
// +--------------------------------------------------------------------------+
// | tb_vga_arb_linebuf : scoreboard bench for vga_arb_linebuf                |
// | Revision           : 1.0                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_vga_arb_linebuf;

  localparam int DEPTH = 3;
  localparam int LANES = 2;
  localparam int BURST = 8;
  localparam int W     = 16;
  localparam int N     = 8;

  logic             sys_clk    = 1'b0;
  logic             sys_rst_n  = 1'b0;
  logic [DEPTH-1:0] a          = '0;
  logic             req        = 1'b0;
  logic [LANES-1:0] we         = '0;
  logic [W-1:0]     di         = '0;
  logic             ack;
  logic [W-1:0]     dout;
  logic             dout_valid;
  logic [DEPTH-1:0] a2         = '0;
  logic             re2        = 1'b0;
  logic [W-1:0]     do2;
  logic             do2_valid;
  logic             fill_start = 1'b0;
  logic [DEPTH-1:0] fill_base  = '0;
  logic             fill_valid = 1'b0;
  logic [W-1:0]     fill_di    = '0;
  logic             fill_busy;
  logic             fill_done;

  vga_arb_linebuf #(.DEPTH(DEPTH), .LANES(LANES), .BURST(BURST)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .a(a), .req(req), .we(we), .di(di),
    .ack(ack), .dout(dout), .dout_valid(dout_valid), .a2(a2), .re2(re2), .do2(do2),
    .do2_valid(do2_valid), .fill_start(fill_start), .fill_base(fill_base),
    .fill_valid(fill_valid), .fill_di(fill_di), .fill_busy(fill_busy), .fill_done(fill_done)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]     m_mem [N];
  logic             m_busy  = 1'b0;
  logic [DEPTH-1:0] m_faddr = '0;
  int               m_cnt   = 0;
  logic             m_done  = 1'b0;
  logic [W-1:0]     q_dout [$];
  logic [W-1:0]     q_do2 [$];
  logic [W-1:0]     last_dout;
  logic [W-1:0]     last_do2;
  logic             have_dout = 1'b0;
  logic             have_do2  = 1'b0;

  function automatic logic [W-1:0] wmerge(input logic [W-1:0] old, input logic [W-1:0] nw,
                                          input logic [LANES-1:0] en);
    logic [W-1:0] r;
    r = old;
    for (int l = 0; l < LANES; l++) if (en[l]) r[8*l +: 8] = nw[8*l +: 8];
    return r;
  endfunction

  task automatic idle();
    req = 1'b0; we = '0; re2 = 1'b0; fill_start = 1'b0; fill_valid = 1'b0;
  endtask

  // One clock: predict from the current inputs, push expectations, clock, pop and compare.
  task automatic cyc();
    logic         exp_ack;
    logic         p1;
    logic         p2;
    logic [W-1:0] nm [N];
    logic [W-1:0] e;
    #1;
    exp_ack = req & ~(m_busy & fill_valid);
    checks++;
    if (ack !== exp_ack) begin
      errors++; $display("FAIL ack got %b exp %b", ack, exp_ack);
    end
    nm = m_mem;
    p1 = sys_rst_n & exp_ack;
    p2 = sys_rst_n & re2;
    if (sys_rst_n) begin
      if (m_busy & fill_valid) nm[m_faddr] = fill_di;
      else if (exp_ack)        nm[a] = wmerge(nm[a], di, we);
    end
`ifdef VGA_ARB_LINEBUF_FWD_EN
    if (p1) q_dout.push_back(nm[a]);
    if (p2) q_do2.push_back(nm[a2]);
`else
    if (p1) q_dout.push_back(m_mem[a]);
    if (p2) q_do2.push_back(m_mem[a2]);
`endif
    m_done = 1'b0;
    if (!sys_rst_n) begin
      m_busy = 1'b0; m_faddr = '0; m_cnt = 0;
    end else if (!m_busy) begin
      if (fill_start) begin m_busy = 1'b1; m_faddr = fill_base; m_cnt = 0; end
    end else if (fill_valid) begin
      if (m_cnt == BURST - 1) begin m_busy = 1'b0; m_done = 1'b1; end
      m_faddr = m_faddr + 1'b1;
      m_cnt++;
    end
    m_mem = nm;
    @(posedge sys_clk);
    #1;
    checks++;
    if (dout_valid !== p1) begin
      errors++; $display("FAIL dout_valid got %b exp %b", dout_valid, p1);
    end
    if (p1) begin
      e = q_dout.pop_front();
      checks++;
      if (dout !== e) begin errors++; $display("FAIL dout got %h exp %h", dout, e); end
      last_dout = e; have_dout = 1'b1;
    end else if (have_dout) begin
      checks++;
      if (dout !== last_dout) begin
        errors++; $display("FAIL dout_hold got %h exp %h", dout, last_dout);
      end
    end
    checks++;
    if (do2_valid !== p2) begin
      errors++; $display("FAIL do2_valid got %b exp %b", do2_valid, p2);
    end
    if (p2) begin
      e = q_do2.pop_front();
      checks++;
      if (do2 !== e) begin errors++; $display("FAIL do2 got %h exp %h", do2, e); end
      last_do2 = e; have_do2 = 1'b1;
    end else if (have_do2) begin
      checks++;
      if (do2 !== last_do2) begin
        errors++; $display("FAIL do2_hold got %h exp %h", do2, last_do2);
      end
    end
    checks++;
    if (fill_busy !== m_busy) begin
      errors++; $display("FAIL fill_busy got %b exp %b", fill_busy, m_busy);
    end
    checks++;
    if (fill_done !== m_done) begin
      errors++; $display("FAIL fill_done got %b exp %b", fill_done, m_done);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; req = 1'b1; we = '0; re2 = 1'b1; fill_start = 1'b1;
    cyc(); cyc();
    idle(); sys_rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_burst_wrap();
    int k;
    int i;
    idle(); fill_start = 1'b1; fill_base = 3'd6; cyc();
    fill_start = 1'b0;
    k = 0; i = 0;
    while (k < BURST) begin
      if (i % 3 == 2) fill_valid = 1'b0;
      else begin fill_valid = 1'b1; fill_di = 16'h1000 + 16'(k); k++; end
      cyc(); i++;
    end
    idle(); cyc();
    for (int ad = 0; ad < N; ad++) begin
      re2 = 1'b1; a2 = 3'(ad); cyc();
      checks++;
      if (do2 !== 16'h1000 + 16'((ad + 2) % N)) begin
        errors++; $display("FAIL burst_word[%0d] got %h exp %h", ad, do2, 16'h1000 + 16'((ad + 2) % N));
      end
    end
    idle();
  endtask

  task automatic test_byte_write();
    idle(); req = 1'b1; a = 3'd3; we = 2'b01; di = 16'hAB12; cyc();
    we = 2'b00; cyc();
    checks++;
    if (dout !== 16'h1012) begin errors++; $display("FAIL byte_write got %h exp %h", dout, 16'h1012); end
    idle(); cyc();
  endtask

  task automatic test_contention();
    idle(); fill_start = 1'b1; fill_base = 3'd0; cyc();
    fill_start = 1'b0;
    fill_valid = 1'b1; fill_di = 16'h2000; req = 1'b1; we = 2'b11; a = 3'd5; di = 16'h5555;
    cyc();
    fill_valid = 1'b0; cyc();
    we = 2'b00; cyc();
    checks++;
    if (dout !== 16'h5555) begin errors++; $display("FAIL contention got %h exp %h", dout, 16'h5555); end
    req = 1'b0;
    for (int k = 1; k < BURST; k++) begin
      fill_valid = 1'b1; fill_di = 16'h2000 + 16'(k); cyc();
    end
    idle(); cyc();
  endtask

  task automatic test_same_addr();
    logic [W-1:0] old;
    old = m_mem[4];
    idle(); fill_start = 1'b1; fill_base = 3'd4; cyc();
    fill_start = 1'b0; fill_valid = 1'b1; fill_di = 16'hBEEF; re2 = 1'b1; a2 = 3'd4;
    cyc();
    checks++;
`ifdef VGA_ARB_LINEBUF_FWD_EN
    if (do2 !== 16'hBEEF) begin errors++; $display("FAIL same_addr got %h exp %h", do2, 16'hBEEF); end
`else
    if (do2 !== old) begin errors++; $display("FAIL same_addr got %h exp %h", do2, old); end
`endif
    re2 = 1'b0;
    for (int k = 1; k < BURST; k++) begin fill_di = 16'h3100 + 16'(k); cyc(); end
    idle(); cyc();
  endtask

  task automatic test_reset_midfill();
    idle(); fill_start = 1'b1; fill_base = 3'd2; cyc();
    fill_start = 1'b0;
    for (int k = 0; k < 3; k++) begin fill_valid = 1'b1; fill_di = 16'h3000 + 16'(k); cyc(); end
    idle(); sys_rst_n = 1'b0; cyc();
    sys_rst_n = 1'b1; fill_valid = 1'b1; fill_di = 16'hDEAD; cyc();
    idle(); cyc();
    for (int k = 0; k < 3; k++) begin
      re2 = 1'b1; a2 = 3'(2 + k); cyc();
      checks++;
      if (do2 !== 16'h3000 + 16'(k)) begin
        errors++; $display("FAIL midfill[%0d] got %h exp %h", k, do2, 16'h3000 + 16'(k));
      end
    end
    idle(); cyc();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 300; c++) begin
      req        = 1'($urandom_range(0, 1));
      we         = 2'($urandom_range(0, 3));
      a          = 3'($urandom_range(0, 7));
      di         = 16'($urandom);
      re2        = 1'($urandom_range(0, 1));
      a2         = 3'($urandom_range(0, 7));
      fill_start = ($urandom_range(0, 15) == 0);
      fill_base  = 3'($urandom_range(0, 7));
      fill_valid = 1'($urandom_range(0, 1));
      fill_di    = 16'($urandom);
      cyc();
    end
    idle(); cyc();
  endtask

  initial begin
    test_reset();
    test_burst_wrap();
    test_byte_write();
    test_contention();
    test_same_addr();
    test_reset_midfill();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
